// File: rtl/pmu_csr_ctrl.sv
// CSR sequencer for the mcycle/minstret counter pair and mcountinhibit.
// Define PMU_SNAPSHOT_EN to add the low-read/high-read snapshot shadow registers.
module pmu_csr_ctrl #(
    parameter int         CNT_WIDTH   = 64,
    parameter logic [2:0] INHIBIT_RST = 3'b000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 csr_req,
    input  logic                 csr_we,
    input  logic [11:0]          csr_addr,
    input  logic [31:0]          csr_wdata,
    output logic                 csr_ready,
    output logic [31:0]          csr_rdata,
    output logic                 csr_err,
    input  logic                 retire_valid,
    input  logic                 pipe_flush,
    input  logic [CNT_WIDTH-1:0] cnt_mcycle_q,
    input  logic [CNT_WIDTH-1:0] cnt_minstret_q,
    output logic                 incr_cycle,
    output logic                 incr_instr,
    output logic                 cnt_we,
    output logic [11:0]          cnt_addr,
    output logic [CNT_WIDTH-1:0] cnt_wdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
    typedef struct packed {
        logic mapped;
        logic ro;
        logic inh;
        logic instr;
        logic hi;
    } dec_t;

    function automatic dec_t decode(input logic [11:0] a);
        dec_t d;
        d = '0;
        case (a)
            12'hB00: d = 5'b10000;
            12'hB80: d = 5'b10001;
            12'hB02: d = 5'b10010;
            12'hB82: d = 5'b10011;
            12'hC00: d = 5'b11000;
            12'hC80: d = 5'b11001;
            12'hC02: d = 5'b11010;
            12'hC82: d = 5'b11011;
            12'h320: d = 5'b10100;
            default: d = 5'b00000;
        endcase
        return d;
    endfunction

    state_t               state_q, state_d;
    logic                 we_q;
    logic [11:0]          addr_q;
    logic [1:0]           inh_wdata_q;
    logic                 inh_cy_q, inh_ir_q;
    dec_t                 dec_in, dec_q;
    logic [CNT_WIDTH-1:0] live_in, live_exec;
    logic                 start, wr_cnt, err;
    logic                 csr_ready_d, csr_err_d, cnt_we_d;
    logic [31:0]          csr_rdata_d, hi_rdata;
    logic [11:0]          cnt_addr_d;
    logic [CNT_WIDTH-1:0] cnt_wdata_d;

    assign dec_in    = decode(csr_addr);
    assign dec_q     = decode(addr_q);
    assign live_in   = dec_in.instr ? cnt_minstret_q : cnt_mcycle_q;
    assign live_exec = dec_q.instr ? cnt_minstret_q : cnt_mcycle_q;
    assign start     = (state_q == IDLE) && csr_req;
    assign wr_cnt    = start && csr_we && dec_in.mapped && !dec_in.ro && !dec_in.inh;
    assign err       = !dec_q.mapped || (we_q && dec_q.ro);

    assign incr_cycle = ~inh_cy_q;
    assign incr_instr = retire_valid & ~pipe_flush & ~inh_ir_q;

`ifdef PMU_SNAPSHOT_EN
    logic [31:0] shadow_cy_q, shadow_ir_q;
    logic [1:0]  shadow_vld_q;

    assign hi_rdata = shadow_vld_q[dec_q.instr] ? (dec_q.instr ? shadow_ir_q : shadow_cy_q)
                                                : live_exec[CNT_WIDTH-1:32];

    // A counter write invalidates that counter's snapshot; reads fill or consume it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_cy_q  <= '0;
            shadow_ir_q  <= '0;
            shadow_vld_q <= '0;
        end else begin
            if (cnt_we)
                shadow_vld_q[cnt_addr[1]] <= 1'b0;
            if (state_q == EXEC && !we_q && dec_q.mapped && !dec_q.inh) begin
                if (dec_q.hi) begin
                    shadow_vld_q[dec_q.instr] <= 1'b0;
                end else begin
                    shadow_vld_q[dec_q.instr] <= 1'b1;
                    if (dec_q.instr)
                        shadow_ir_q <= live_exec[CNT_WIDTH-1:32];
                    else
                        shadow_cy_q <= live_exec[CNT_WIDTH-1:32];
                end
            end
        end
    end
`else
    assign hi_rdata = live_exec[CNT_WIDTH-1:32];
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (csr_req) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter writes are launched from the request cycle so cnt_we lands in EXEC.
    always_comb begin
        cnt_we_d    = wr_cnt;
        cnt_addr_d  = cnt_addr;
        cnt_wdata_d = cnt_wdata;
        if (wr_cnt) begin
            cnt_addr_d  = dec_in.instr ? 12'hB02 : 12'hB00;
            cnt_wdata_d = dec_in.hi ? {csr_wdata, live_in[31:0]}
                                    : {live_in[CNT_WIDTH-1:32], csr_wdata};
        end
        csr_ready_d = (state_q == EXEC);
        csr_err_d   = (state_q == EXEC) && err;
        csr_rdata_d = csr_rdata;
        if (state_q == EXEC) begin
            csr_rdata_d = '0;
            if (!err && !we_q) begin
                if (dec_q.inh)
                    csr_rdata_d = {29'b0, inh_ir_q, 1'b0, inh_cy_q};
                else if (dec_q.hi)
                    csr_rdata_d = hi_rdata;
                else
                    csr_rdata_d = live_exec[31:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            we_q        <= csr_we;
            addr_q      <= csr_addr;
            inh_wdata_q <= {csr_wdata[2], csr_wdata[0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            csr_ready <= 1'b0;
            csr_err   <= 1'b0;
            csr_rdata <= '0;
            cnt_we    <= 1'b0;
            cnt_addr  <= 12'h000;
            cnt_wdata <= '0;
            inh_cy_q  <= INHIBIT_RST[0];
            inh_ir_q  <= INHIBIT_RST[2];
        end else begin
            state_q   <= state_d;
            csr_ready <= csr_ready_d;
            csr_err   <= csr_err_d;
            csr_rdata <= csr_rdata_d;
            cnt_we    <= cnt_we_d;
            cnt_addr  <= cnt_addr_d;
            cnt_wdata <= cnt_wdata_d;
            if (state_q == EXEC && we_q && dec_q.inh)
                {inh_ir_q, inh_cy_q} <= inh_wdata_q;
        end
    end

endmodule

// File: tb/tb_pmu_csr_ctrl.sv
// Bench for pmu_csr_ctrl: transaction-level model with per-cycle compare plus literal checks.
module tb_pmu_csr_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_req, csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_ready;
    logic [31:0] csr_rdata;
    logic        csr_err;
    logic        retire_valid, pipe_flush;
    logic [63:0] cnt_mcycle_q, cnt_minstret_q;
    logic        incr_cycle, incr_instr, cnt_we;
    logic [11:0] cnt_addr;
    logic [63:0] cnt_wdata;

    pmu_csr_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .csr_req(csr_req), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_ready(csr_ready), .csr_rdata(csr_rdata), .csr_err(csr_err),
        .retire_valid(retire_valid), .pipe_flush(pipe_flush),
        .cnt_mcycle_q(cnt_mcycle_q), .cnt_minstret_q(cnt_minstret_q),
        .incr_cycle(incr_cycle), .incr_instr(incr_instr),
        .cnt_we(cnt_we), .cnt_addr(cnt_addr), .cnt_wdata(cnt_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Architectural model state and per-cycle expectations keyed by cycle number.
    bit          arch_cy, arch_ir, eff_cy, eff_ir;
`ifdef PMU_SNAPSHOT_EN
    logic [31:0] sh [2];
    bit          sv [2];
`endif
    bit          exp_we    [int];
    logic [11:0] exp_waddr [int];
    logic [63:0] exp_wdata [int];
    bit          exp_ready [int];
    bit          exp_err   [int];
    logic [31:0] exp_rdata [int];
    bit          exp_rdchk [int];
    logic [1:0]  inh_sched [int];

    function automatic void model_access(input int n, input bit we, input logic [11:0] a,
                                         input logic [31:0] wd);
        bit mapped, ro, inh, ins, hi, err;
        logic [63:0] live;
        logic [31:0] rd;
        mapped = 1'b1; inh = 1'b0; ins = 1'b0; hi = 1'b0;
        ro = (a[11:8] == 4'hC);
        case (a)
            12'hB00, 12'hC00: ;
            12'hB80, 12'hC80: hi = 1'b1;
            12'hB02, 12'hC02: ins = 1'b1;
            12'hB82, 12'hC82: begin ins = 1'b1; hi = 1'b1; end
            12'h320:          inh = 1'b1;
            default:          mapped = 1'b0;
        endcase
        err  = !mapped || (we && ro);
        live = ins ? cnt_minstret_q : cnt_mcycle_q;
        rd   = 32'h0;
        if (!err && we && inh) begin
            arch_cy = wd[0];
            arch_ir = wd[2];
            inh_sched[n+2] = {wd[2], wd[0]};
        end else if (!err && we) begin
            exp_we[n+1]    = 1'b1;
            exp_waddr[n+1] = ins ? 12'hB02 : 12'hB00;
            exp_wdata[n+1] = hi ? {wd, live[31:0]} : {live[63:32], wd};
`ifdef PMU_SNAPSHOT_EN
            sv[ins] = 1'b0;
`endif
        end else if (!err && inh) begin
            rd = {29'd0, arch_ir, 1'b0, arch_cy};
        end else if (!err && !hi) begin
            rd = live[31:0];
`ifdef PMU_SNAPSHOT_EN
            sh[ins] = live[63:32];
            sv[ins] = 1'b1;
`endif
        end else if (!err) begin
            rd = live[63:32];
`ifdef PMU_SNAPSHOT_EN
            if (sv[ins]) rd = sh[ins];
            sv[ins] = 1'b0;
`endif
        end
        exp_ready[n+2] = 1'b1;
        exp_err[n+2]   = err;
        exp_rdata[n+2] = rd;
        exp_rdchk[n+2] = err || !we;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            eff_cy = 1'b0;
            eff_ir = 1'b0;
        end else begin
            if (inh_sched.exists(cyc)) begin
                {eff_ir, eff_cy} = inh_sched[cyc];
                inh_sched.delete(cyc);
            end
            check("incr_cycle", incr_cycle, !eff_cy);
            check("incr_instr", incr_instr, retire_valid & ~pipe_flush & ~eff_ir);
            check("cnt_we", cnt_we, exp_we.exists(cyc));
            if (exp_we.exists(cyc)) begin
                check("cnt_addr", cnt_addr, exp_waddr[cyc]);
                check("cnt_wdata", cnt_wdata, exp_wdata[cyc]);
            end
            check("csr_ready", csr_ready, exp_ready.exists(cyc));
            if (exp_ready.exists(cyc)) begin
                check("csr_err", csr_err, exp_err[cyc]);
                if (exp_rdchk[cyc]) check("csr_rdata", csr_rdata, exp_rdata[cyc]);
            end
        end
    end

    // Called #1 after a rising edge with the DUT idle; returns #1 after the edge that re-enters IDLE.
    task automatic access(input bit we, input logic [11:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output bit er, output logic [63:0] wdat);
        model_access(cyc, we, a, wd);
        csr_req = 1'b1; csr_we = we; csr_addr = a; csr_wdata = wd;
        @(posedge clk); #1;
        csr_req = 1'b0;
        @(negedge clk);
        wdat = cnt_wdata;
        @(posedge clk); #1;
        @(negedge clk);
        rd = csr_rdata;
        er = csr_err;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        bit          er;
        logic [63:0] wd;
        rst_n = 1'b0; csr_req = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
        retire_valid = 1'b0; pipe_flush = 1'b0; cnt_mcycle_q = '0; cnt_minstret_q = '0;
        arch_cy = 1'b0; arch_ir = 1'b0;
`ifdef PMU_SNAPSHOT_EN
        sv[0] = 1'b0; sv[1] = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst csr_ready", csr_ready, 0);
        check("rst cnt_we", cnt_we, 0);
        check("rst cnt_addr", cnt_addr, 0);
        check("rst cnt_wdata", cnt_wdata, 0);
        check("rst csr_rdata", csr_rdata, 0);
        check("rst incr_cycle", incr_cycle, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        access(1'b0, 12'h320, 32'h0, rd, er, wd);
        check("inhibit reset read", rd, 32'h0);

        cnt_mcycle_q = 64'h0000_0007_FFFF_FFF0;
        access(1'b1, 12'hB00, 32'h1234_5678, rd, er, wd);
        check("low write wdata", wd, 64'h0000_0007_1234_5678);
        access(1'b1, 12'hB80, 32'hAAAA_5555, rd, er, wd);
        check("high write wdata", wd, 64'hAAAA_5555_FFFF_FFF0);

        cnt_minstret_q = 64'h0000_0123_0000_0456;
        access(1'b0, 12'hC02, 32'h0, rd, er, wd);
        check("minstret low read", rd, 32'h456);
        access(1'b0, 12'hB82, 32'h0, rd, er, wd);
        check("minstret high read", rd, 32'h123);
        access(1'b1, 12'hB82, 32'h0000_00FF, rd, er, wd);
        check("minstret high write", wd, 64'h0000_00FF_0000_0456);

        access(1'b1, 12'hC02, 32'hDEAD_BEEF, rd, er, wd);
        check("ro write err", er, 1);
        check("ro write rdata", rd, 32'h0);
        access(1'b0, 12'h7C0, 32'h0, rd, er, wd);
        check("unmapped err", er, 1);
        check("unmapped rdata", rd, 32'h0);

        retire_valid = 1'b1; pipe_flush = 1'b1;
        @(negedge clk);
        check("flush gates instr", incr_instr, 0);
        @(posedge clk); #1;
        pipe_flush = 1'b0;
        @(negedge clk);
        check("retire counts", incr_instr, 1);
        @(posedge clk); #1;

        access(1'b1, 12'h320, 32'h5, rd, er, wd);
        check("inhibited cycle", incr_cycle, 0);
        check("inhibited instr", incr_instr, 0);
        access(1'b0, 12'h320, 32'h0, rd, er, wd);
        check("inhibit read 5", rd, 32'h5);
        access(1'b1, 12'h320, 32'h0, rd, er, wd);
        check("uninhibited cycle", incr_cycle, 1);
        access(1'b1, 12'h320, 32'hFFFF_FFFF, rd, er, wd);
        access(1'b0, 12'h320, 32'h0, rd, er, wd);
        check("inhibit masked read", rd, 32'h5);

        cnt_mcycle_q = 64'h0000_0001_FFFF_FFFE;
        access(1'b0, 12'hB00, 32'h0, rd, er, wd);
        check("snap low read", rd, 32'hFFFF_FFFE);
        cnt_mcycle_q = 64'h0000_0002_0000_0003;
        access(1'b0, 12'hB80, 32'h0, rd, er, wd);
`ifdef PMU_SNAPSHOT_EN
        check("snap high read", rd, 32'h1);
`else
        check("snap high read", rd, 32'h2);
`endif
        access(1'b0, 12'hC80, 32'h0, rd, er, wd);
        check("second high read", rd, 32'h2);

        cnt_minstret_q = 64'h0000_0005_0000_0010;
        access(1'b0, 12'hB02, 32'h0, rd, er, wd);
        cnt_minstret_q = 64'h0000_0006_0000_0000;
        access(1'b1, 12'hB02, 32'h20, rd, er, wd);
        check("minstret low write", wd, 64'h0000_0006_0000_0020);
        access(1'b0, 12'hB82, 32'h0, rd, er, wd);
        check("write clears snapshot", rd, 32'h6);

        // Abort a write in its EXEC cycle.
        csr_req = 1'b1; csr_we = 1'b1; csr_addr = 12'hB02; csr_wdata = 32'h77;
        @(posedge clk); #1;
        csr_req = 1'b0;
        rst_n = 1'b0;
        arch_cy = 1'b0; arch_ir = 1'b0;
`ifdef PMU_SNAPSHOT_EN
        sv[0] = 1'b0; sv[1] = 1'b0;
`endif
        #1;
        check("abort cnt_we", cnt_we, 0);
        check("abort csr_ready", csr_ready, 0);
        check("abort cnt_addr", cnt_addr, 0);
        check("abort cnt_wdata", cnt_wdata, 0);
        check("abort csr_rdata", csr_rdata, 0);
        check("abort incr_cycle", incr_cycle, 1);
        @(posedge clk); #1;
        check("abort held cnt_we", cnt_we, 0);
        check("abort held csr_ready", csr_ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 12'h320, 32'h0, rd, er, wd);
        check("post-abort inhibit", rd, 32'h0);
        check("post-abort err", er, 0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
